mips_fetch_unit: RTL
====================

# mips_fetch_unit

Instruction-fetch front end for the multicycle MIPS core, directly upstream of the controller. It holds the PC and runs a request/acknowledge handshake to instruction memory, which has a variable number of wait states. It latches the returned word into the instruction register and presents OpCode/Funct to the controller. It also guarantees a stable memory address while a request is outstanding and flags hung memory with a sticky fault.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00
- TIMEOUT, 16, maximum wait cycles after mem_req rises before fault; legal range 1..255

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  controller request to fetch the instruction at pc; sampled each edge
- pc_write  in  1  load pc from pc_next (the controller's PCWrite)
- pc_next  in  32  new PC value from the ALU/PC mux
- mem_addr  out  32  instruction memory address
- mem_req  out  1  memory read request; level, held until acknowledged
- mem_ack  in  1  memory read complete; mem_rdata is valid in the same cycle
- mem_rdata  in  32  instruction word
- pc  out  32  current PC; bits [1:0] always 00
- instr  out  32  instruction register
- OpCode  out  6  instr[31:26]
- Funct  out  6  instr[5:0]
- instr_valid  out  1  instr holds a completed fetch
- busy  out  1  a request is outstanding
- fault  out  1  sticky memory timeout
- fetch_count  out  32  completed fetches; wraps at 2^32

## Operation

- State machine states:
  - IDLE: no request outstanding.
  - REQ: mem_req high, waiting for mem_ack.
  - FAULT: terminal until rst.
- Reset (asynchronous) values:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0.
  - mem_req=0, busy=0, fault=0, fetch_count=0, wait counter=0, pending-PC valid=0.
- IDLE:
  - fetch_req=1 moves to REQ, asserts mem_req, clears instr_valid, zeroes the wait counter.
  - mem_addr always equals pc.
- REQ:
  - mem_req=1, busy=1; the wait counter increments each cycle that mem_ack=0.
  - mem_ack=1: instr<=mem_rdata, instr_valid<=1, fetch_count increments, mem_req<=0, state->IDLE.
  - No ack after TIMEOUT counted cycles: state->FAULT, mem_req<=0, fault<=1.
  - If mem_ack and the timeout coincide, the ack wins.
- FAULT:
  - mem_req=0, busy=0, fault=1.
  - fetch_req and pc_write are ignored.
  - instr and instr_valid are frozen.
- pc_write outside REQ: pc<={pc_next[31:2],2'b00} at that edge; bits [1:0] of pc_next are dropped.
- pc_write during REQ: captured into a pending register, so mem_addr never changes mid-request.
  - The pending value is applied to pc on the edge that completes the request.
  - A later pc_write in the same REQ overwrites the pending value (last write wins).
- pc_write together with a fetch_req sampled in IDLE: the new pc is loaded, and the fetch uses the OLD pc.
  - mem_addr is registered from pc at request launch and held through REQ.
- fetch_req while in REQ or FAULT is ignored; requests are not queued.
- instr stays stable while instr_valid=1 and until the next completed fetch.
- OpCode and Funct are combinational slices of instr.

## Timing

- fetch_req sampled at edge t: mem_req=1 and busy=1 from just after t.
- Minimum latency: mem_ack in the first REQ cycle (sampled at t+1) gives instr_valid=1 after edge t+1, i.e. 2 edges after fetch_req.
- With N wait cycles (mem_ack sampled at edge t+1+N): instr_valid=1 after edge t+1+N.
- Timeout: with no ack, fault=1 after edge t+TIMEOUT.
- mem_req drops on the same edge that captures the ack; the memory must not ack when mem_req=0.
- Back-to-back: fetch_req may be reasserted in the cycle after completion, giving one IDLE cycle between requests.
- Asserting rst mid-REQ drops mem_req immediately (asynchronously); any in-flight ack is discarded.

## Test plan

1. Reset, then fetch_req at RESET_PC=0 with zero-wait memory returning 32'h2008_0005 → mem_addr=0, instr_valid after 2 edges, OpCode=6'b001000, fetch_count=1.
2. Memory acks after 3 wait cycles with 32'h0109_5020; pc_write with pc_next=32'h4 pulsed during REQ → mem_addr stays 0 throughout, instr=32'h0109_5020, Funct=6'b100000, pc=4 on the completion edge.
3. pc_next=32'h0000_0013 written in IDLE → pc=32'h0000_0010; the next fetch drives mem_addr=32'h10.
4. TIMEOUT=16 with memory never acking → fault=1 and mem_req=0 exactly 16 edges after launch; a later fetch_req causes no new mem_req; instr is unchanged.
5. mem_ack arrives on the TIMEOUT-th wait cycle → fetch completes and fault stays 0.
6. rst asserted mid-REQ → mem_req=0 immediately, pc=RESET_PC, instr_valid=0, fetch_count=0; an ack arriving during rst has no effect.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC, request/ack handshake to instruction
// memory with variable wait states, instruction register and timeout fault.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic        instr_valid,
    output logic        busy,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FAULT
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        launch;
    logic        done;
    logic        tmo;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] pend_pc;
    logic        pend_valid;
    logic [31:0] pc_aligned;

    assign pc_aligned = pc_next & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        done       = 1'b0;
        tmo        = 1'b0;
        case (state)
            S_IDLE: begin
                if (fetch_req) begin
                    state_next = S_REQ;
                    launch     = 1'b1;
                end
            end
            S_REQ: begin
                // An ack on the timeout edge still completes the fetch
                if (mem_ack) begin
                    state_next = S_IDLE;
                    done       = 1'b1;
                end else if (wait_cnt == TMO_LAST) begin
                    state_next = S_FAULT;
                    tmo        = 1'b1;
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC & 32'hFFFF_FFFC;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
            wait_cnt    <= '0;
            addr_q      <= '0;
            pend_pc     <= '0;
            pend_valid  <= 1'b0;
        end else begin
            if (launch) begin
                addr_q      <= pc;
                instr_valid <= 1'b0;
                wait_cnt    <= '0;
            end
            if (state == S_REQ && !mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (done) begin
                instr       <= mem_rdata;
                instr_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
            // PC writes during a request are deferred so mem_addr holds
            if (state == S_IDLE && pc_write) begin
                pc <= pc_aligned;
            end else if (state == S_REQ) begin
                if (done) begin
                    pend_valid <= 1'b0;
                    if (pc_write) begin
                        pc <= pc_aligned;
                    end else if (pend_valid) begin
                        pc <= pend_pc;
                    end
                end else if (tmo) begin
                    pend_valid <= 1'b0;
                end else if (pc_write) begin
                    pend_pc    <= pc_aligned;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    assign mem_req  = (state == S_REQ);
    assign busy     = (state == S_REQ);
    assign fault    = (state == S_FAULT);
    assign mem_addr = (state == S_REQ) ? addr_q : pc;
    assign OpCode   = instr[31:26];
    assign Funct    = instr[5:0];

endmodule
